pe_array_gen: RTL
=================

Name: pe_array_gen

Overview:
- Parametrised output-stationary systolic MAC array, ROWS x COLS, successor to the fixed 4x4 8-bit array.
- Adds built-in input skew, signed/unsigned mode and valid/ready input.
- Adds an internal flush/drain controller that streams all accumulators out row-major over a valid/ready port.
- Sits between the operand buffers and the result writeback / requantisation stage.

Parameters:
- ROWS, 4, array rows (>=1); each row receives one data operand stream.
- COLS, 4, array columns (>=1); each column receives one weight operand stream.
- DW, 8, operand width.
- AW, 32, accumulator and result width (>= 2*DW).
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  ROWS*DW  row r operand at bits [r*DW +: DW]
- weight_in  in  COLS*DW  column c operand at bits [c*DW +: DW]
- in_valid  in  1  operand vector valid
- in_ready  out  1  block accepts an operand vector this cycle
- acc_clr  in  1  synchronous clear of all accumulators (honoured in IDLE only)
- drain_start  in  1  request flush and readout (honoured in IDLE only)
- busy  out  1  state != IDLE
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  AW  accumulator value
- out_row  out  max(1,clog2(ROWS))  row of current result
- out_col  out  max(1,clog2(COLS))  column of current result
- out_last  out  1  current result is index ROWS*COLS-1

Behaviour:
- Reset (async, rst_n=0): state IDLE; all skew, operand and accumulator registers 0; drain index 0; in_ready=0 while in reset; out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0.
- Datapath advances every cycle outside DRAIN.
  - Edge injection = accepted sample if in_valid&in_ready, else zeros.
  - Row r injection passes r skew stages, then enters a_q(r,0); a_q(r,c) <= a_q(r,c-1).
  - Column c injection passes c skew stages, then enters b_q(0,c); b_q(r,c) <= b_q(r-1,c).
  - acc(r,c) <= acc(r,c) + ext(a_q*b_q). Product is 2*DW bits, sign- or zero-extended per SIGNED to AW; sum wraps modulo 2^AW with no saturation.
  - Sample accepted at edge of cycle t is in acc(r,c) after edge ending cycle t+1+r+c.
- in_ready = (state==IDLE) & ~acc_clr.
- IDLE transitions and rules:
  - acc_clr=1: next edge zeroes all skew, operand and accumulator regs. Priority over in_valid and drain_start, which are ignored that cycle.
  - drain_start=1 (no acc_clr) -> FLUSH. A sample accepted in the same cycle is included in the results.
  - acc_clr, drain_start and in_valid are ignored outside IDLE.
- FLUSH:
  - Lasts exactly ROWS+COLS-1 cycles.
  - Zeros injected, accumulators keep updating; counter then -> DRAIN.
  - Results in DRAIN are final: drain_start accepted in cycle T gives first out_valid in cycle T+ROWS+COLS.
- DRAIN:
  - Accumulators and operand regs frozen.
  - out_valid=1; out_data=acc(out_row,out_col); index starts 0, row-major (col fastest).
  - Index advances only on out_valid&out_ready.
  - While out_valid&~out_ready, out_data/out_row/out_col/out_last hold stable.
  - Handshake with out_last=1: all accumulators and operand regs clear, index -> 0, state -> IDLE, out_valid=0 next cycle.
- out_data/out_row/out_col/out_last: 0 outside DRAIN.
- ROWS=1 or COLS=1: index width 1, skew of 0 stages; FLUSH length still ROWS+COLS-1.
- Reset mid-operation (any state): immediate return to reset values; partial results discarded.

Test Plan:
- Default params; one sample (all data=1, all weights=2), drain_start same cycle T -> first out_valid at T+8; 16 results all 2; out_row/out_col sweep (0,0)..(3,3); out_last only on (3,3); busy drops after last handshake.
- Three samples with data row r = r+1, weight col c = c+1, then drain -> acc(r,c)=3(r+1)(c+1), e.g. (3,3)=48, (0,2)=9.
- SIGNED=1, data=-128, weight=-128, one sample -> every result 16384. SIGNED=1, data=-3, weight=5 -> 0xFFFFFFF1. SIGNED=0, 255*255 -> 65025.
- out_ready toggled 1-0-0-1 pseudo-randomly during drain -> no index skipped or repeated, outputs stable while stalled, all 16 values correct. in_valid during DRAIN ignored (in_ready=0).
- acc_clr asserted with in_valid after 2 samples, then 1 sample of 1x1, drain -> all results 1. Second drain with no new samples -> all 0 (auto-clear).
- AW=16, SIGNED=0: two samples 255*255 -> 130050 mod 65536 = 64514. Reset asserted at drain index 5 -> out_valid=0, busy=0 immediately; subsequent drain yields all 0.

Source files
------------

// File: rtl/pe_array_gen.sv
// Output-stationary ROWS x COLS systolic MAC array with input skew,
// flush/drain controller and a row-major valid/ready result port.
module pe_array_gen #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DW     = 8,
  parameter int AW     = 32,
  parameter int SIGNED = 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ROWS*DW-1:0] data_in,
  input  logic [COLS*DW-1:0] weight_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               acc_clr,
  input  logic               drain_start,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AW-1:0]      out_data,
  output logic [RW-1:0]      out_row,
  output logic [CW-1:0]      out_col,
  output logic               out_last
);

  localparam int FW = $clog2(ROWS + COLS);
  localparam logic [FW-1:0] FLAST = FW'(ROWS + COLS - 2);

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] cnt_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;

  logic [DW-1:0] a_edge [ROWS];
  logic [DW-1:0] b_edge [COLS];
  logic [DW-1:0] a_q    [ROWS][COLS];
  logic [DW-1:0] b_q    [ROWS][COLS];
  logic [AW-1:0] acc    [ROWS][COLS];

  logic fire, adv, clr, out_hs, last, flush_done;

  assign in_ready   = rst_n & (state_q == IDLE) & ~acc_clr;
  assign busy       = (state_q != IDLE);
  assign fire       = in_valid & in_ready;
  assign adv        = (state_q != DRAIN);
  assign last       = (row_q == RW'(ROWS - 1)) &&
                      (col_q == CW'(COLS - 1));
  assign out_hs     = out_valid & out_ready;
  assign flush_done = (state_q == FLUSH) && (cnt_q == FLAST);
  assign clr        = ((state_q == IDLE) && acc_clr) ||
                      (out_hs && last);

  // Product of two operands, extended to accumulator width.
  function automatic logic [AW-1:0] mext(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic signed [DW:0]          sa;
    logic signed [DW:0]          sb;
    logic signed [2*DW+1:0]      p;
    logic signed [AW+2*DW+1:0]   w;
    sa = {(SIGNED != 0) & a[DW-1], a};
    sb = {(SIGNED != 0) & b[DW-1], b};
    p  = sa * sb;
    w  = (AW + 2 * DW + 2)'(p);
    return w[AW-1:0];
  endfunction

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DW-1:0] inj;
    assign inj = fire ? data_in[r*DW +: DW] : '0;
    if (r == 0) begin : g_direct
      assign a_edge[r] = inj;
    end else begin : g_skew
      logic [DW-1:0] sk [r];
      // Row skew line: r delay stages ahead of column 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < r; k++) sk[k] <= '0;
        end else if (clr) begin
          for (int k = 0; k < r; k++) sk[k] <= '0;
        end else if (adv) begin
          sk[0] <= inj;
          for (int k = 1; k < r; k++) sk[k] <= sk[k-1];
        end
      end
      assign a_edge[r] = sk[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [DW-1:0] inj;
    assign inj = fire ? weight_in[c*DW +: DW] : '0;
    if (c == 0) begin : g_direct
      assign b_edge[c] = inj;
    end else begin : g_skew
      logic [DW-1:0] sk [c];
      // Column skew line: c delay stages ahead of row 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < c; k++) sk[k] <= '0;
        end else if (clr) begin
          for (int k = 0; k < c; k++) sk[k] <= '0;
        end else if (adv) begin
          sk[0] <= inj;
          for (int k = 1; k < c; k++) sk[k] <= sk[k-1];
        end
      end
      assign b_edge[c] = sk[c-1];
    end
  end

  // PE grid: operands shift right/down, accumulators integrate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          acc[i][j] <= '0;
        end
    end else if (clr) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          acc[i][j] <= '0;
        end
    end else if (adv) begin
      for (int i = 0; i < ROWS; i++) begin
        a_q[i][0] <= a_edge[i];
        for (int j = 1; j < COLS; j++)
          a_q[i][j] <= a_q[i][j-1];
      end
      for (int j = 0; j < COLS; j++) begin
        b_q[0][j] <= b_edge[j];
        for (int i = 1; i < ROWS; i++)
          b_q[i][j] <= b_q[i-1][j];
      end
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          acc[i][j] <= acc[i][j] + mext(a_q[i][j], b_q[i][j]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!acc_clr && drain_start) state_d = FLUSH;
      FLUSH:   if (flush_done) state_d = DRAIN;
      DRAIN:   if (out_hs && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flush length counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt_q <= '0;
    else if (state_q != FLUSH)  cnt_q <= '0;
    else if (flush_done)        cnt_q <= '0;
    else                        cnt_q <= cnt_q + 1'b1;
  end

  // Drain index, row-major with column fastest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (out_hs) begin
      if (last) begin
        row_q <= '0;
        col_q <= '0;
      end else if (col_q == CW'(COLS - 1)) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Result port outputs.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    out_last  = 1'b0;
    if (state_q == DRAIN) begin
      out_valid = 1'b1;
      out_data  = acc[row_q][col_q];
      out_row   = row_q;
      out_col   = col_q;
      out_last  = last;
    end
  end

endmodule
